predecode_fetch_sequencer: RTL
==============================

# predecode_fetch_sequencer

Sequences fetch packets into the PreDecode datapath. Holds each packet in one pipeline register that drives PreDecode's seventeen `io_in_bits_data_*` halfwords. Uses PreDecode's per-slot `isRVC` feedback to compute true instruction-start masks from the packet's start offset. Carries an RVI instruction that straddles two packets into the next packet. Sits between the ICache data return and the IFU predecode/check stage.

## Interface
Parameters:
- PACKET_HALVES, 16, instruction slots per packet; data carries PACKET_HALVES+1 halfwords (the last is lookahead)
- HALF_W, 16, halfword width
- SEQ_W, 8, packet sequence-number width

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_flush  in  1  redirect; kills held packet and carry state
- io_in_valid  in  1  packet offered
- io_in_ready  out  1  packet accepted when valid&&ready
- io_in_data  in  17*HALF_W  halfwords 0..16, halfword i at bits [16i+15:16i]
- io_in_startOffset  in  4  first halfword belonging to this packet
- io_in_endOffset  in  4  last halfword belonging to this packet
- io_pd_data  out  17*HALF_W  registered; drives PreDecode data inputs 0..16
- io_pd_isRVC  in  16  PreDecode pd_i_isRVC feedback, combinational from io_pd_data
- io_out_valid  out  1  held packet valid
- io_out_ready  in  1  consumer accepts
- io_out_instValid  out  16  instruction-start mask
- io_out_halfTail  out  1  last instruction is RVI at slot 15; its upper half is halfword 16
- io_out_seq  out  SEQ_W  sequence number of held packet

## Operation
- FSM states:
  - EMPTY: no packet held.
  - FULL: packet held, io_out_valid=1.
- FSM transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out fire without accept.
  - FULL→FULL on out fire with simultaneous accept.
  - Any state→EMPTY on io_flush.
- io_in_ready = (state==EMPTY) || io_out_ready. io_in_ready is forced 0 while io_flush=1.
- On accept, register the following:
  - data and endOffset.
  - effStart = startOffset + carry, computed 5 bits wide; value 16 is legal.
  - the current seq counter.
- Boundary scan over slots i=0..15 (combinational, from held state):
  - inRange(i) = effStart ≤ i ≤ endOffset.
  - start(effStart)=1.
  - For i>effStart: start(i) = start(i-1) ? isRVC(i-1) : 1.
  - instValid(i) = inRange(i) && start(i).
- halfTail = instValid[15] && !isRVC[15] && endOffset==15.
- carry: set to halfTail on out fire. Cleared on out fire when halfTail=0, on flush, and on reset.
- seq counter increments by 1 per accepted packet, modulo 2^SEQ_W. It is not cleared by flush.
- Boundary cases:
  - effStart>endOffset or effStart==16: instValid=0, halfTail=0, packet still emitted.
  - endOffset<15: halfTail=0 regardless of slot 15.
  - Flush in the same cycle as accept or out fire: flush wins. No accept, and carry is cleared.

## Timing
- Reset values:
  - state EMPTY
  - io_out_valid 0
  - io_pd_data 0
  - io_out_instValid 0
  - io_out_halfTail 0
  - io_out_seq 0
  - carry 0
  - seq counter 0
  - io_in_ready 1
- Latency: accept in cycle N → io_out_valid, io_pd_data, and masks valid in N+1.
- Full throughput of one packet per cycle when io_out_ready=1.
- io_out_* are stable while io_out_valid && !io_out_ready.
- Reset mid-stream discards the held packet and carry state.

## Configuration
- PREDECODE_SEQ_PERF_EN:
  - When defined: adds 32-bit saturating counters io_perf_stallCycles (io_out_valid&&!io_out_ready) and io_perf_carryPackets (carry applied on accept), both outputs. Both clear on reset only.
  - When undefined: these counters and ports are absent.

## Structure
- Package predecode_pkg:
  - PACKET_HALVES, HALF_W, SEQ_W
  - typedef half_t
  - seq_state_e {EMPTY, FULL}
- Sub-module predecode_boundary_scan: purely combinational. Inputs effStart, endOffset, isRVC. Outputs instValid, halfTail.

## Test plan
- All-RVC packet, startOffset=0, endOffset=15 → instValid=0xFFFF, halfTail=0, output one cycle after accept.
- All-RVI packet, start 0, end 15 → instValid=0x5555, halfTail=0; next packet start 0 → effStart 0, instValid=0x5555.
- Slot 15 RVI with start 1 on RVI chain → instValid=0xAAAA, halfTail=1; next packet start 0 gets effStart=1 → instValid bit0=0.
- startOffset=15 with carry=1 → effStart=16, instValid=0, halfTail=0, carry cleared after fire.
- io_out_ready held 0 for 3 cycles → io_in_ready=0, outputs stable, seq unchanged; release → seq increments by 1 per packet, 0xFF wraps to 0x00.
- Flush with carry=1 and a packet held, concurrent io_in_valid → io_out_valid=0 next cycle, carry=0, input not accepted.

Source files
------------

// File: rtl/predecode_pkg.sv
// Shared types and sizing for the predecode fetch sequencer.
package predecode_pkg;

  localparam int PACKET_HALVES = 16;
  localparam int HALF_W        = 16;
  localparam int SEQ_W         = 8;

  typedef logic [HALF_W-1:0] half_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/predecode_boundary_scan.sv
// Combinational instruction-start scan over one held packet, driven by
// PreDecode's per-slot isRVC feedback.
module predecode_boundary_scan
  import predecode_pkg::*;
(
  input  logic [4:0]               eff_start,
  input  logic [3:0]               end_offset,
  input  logic [PACKET_HALVES-1:0] is_rvc,
  output logic [PACKET_HALVES-1:0] inst_valid,
  output logic                     half_tail
);

  logic run;
  logic prev_rvc;

  // run tracks start(i): an RVI start makes the following slot its upper half.
  always_comb begin
    run        = 1'b0;
    prev_rvc   = 1'b0;
    inst_valid = '0;
    for (int i = 0; i < PACKET_HALVES; i++) begin
      if (eff_start == 5'(i)) begin
        run = 1'b1;
      end else if (eff_start < 5'(i)) begin
        run = run ? prev_rvc : 1'b1;
      end
      inst_valid[i] = run && (eff_start <= 5'(i)) && (4'(i) <= end_offset);
      prev_rvc      = is_rvc[i];
    end
    half_tail = inst_valid[PACKET_HALVES-1] && !is_rvc[PACKET_HALVES-1] &&
                (end_offset == 4'd15);
  end

endmodule

// File: rtl/predecode_fetch_sequencer.sv
// Single-entry fetch-packet holding register feeding PreDecode, with straddling
// RVI carry and sequence tagging. Optional perf counters: PREDECODE_SEQ_PERF_EN.
//
// state | meaning
// EMPTY | no packet held
// FULL  | packet held, io_out_valid=1
module predecode_fetch_sequencer #(
  parameter int PACKET_HALVES = predecode_pkg::PACKET_HALVES,
  parameter int HALF_W        = predecode_pkg::HALF_W,
  parameter int SEQ_W         = predecode_pkg::SEQ_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              io_flush,
  input  logic                              io_in_valid,
  output logic                              io_in_ready,
  input  logic [(PACKET_HALVES+1)*HALF_W-1:0] io_in_data,
  input  logic [3:0]                        io_in_startOffset,
  input  logic [3:0]                        io_in_endOffset,
  output logic [(PACKET_HALVES+1)*HALF_W-1:0] io_pd_data,
  input  logic [PACKET_HALVES-1:0]          io_pd_isRVC,
  output logic                              io_out_valid,
  input  logic                              io_out_ready,
  output logic [PACKET_HALVES-1:0]          io_out_instValid,
  output logic                              io_out_halfTail,
  output logic [SEQ_W-1:0]                  io_out_seq
`ifdef PREDECODE_SEQ_PERF_EN
  ,
  output logic [31:0]                       io_perf_stallCycles,
  output logic [31:0]                       io_perf_carryPackets
`endif
);

  import predecode_pkg::*;

  seq_state_e              state;
  logic                    carry;
  logic [4:0]              eff_start;
  logic [3:0]              end_offset;
  logic [SEQ_W-1:0]        seq_cnt;
  logic [PACKET_HALVES-1:0] scan_valid;
  logic                    scan_tail;
  logic                    accept;
  logic                    out_fire;
  logic                    carry_in;

  predecode_boundary_scan u_scan (
    .eff_start  (eff_start),
    .end_offset (end_offset),
    .is_rvc     (io_pd_isRVC),
    .inst_valid (scan_valid),
    .half_tail  (scan_tail)
  );

  assign io_out_valid     = (state == FULL);
  assign io_in_ready      = !io_flush && ((state == EMPTY) || io_out_ready);
  assign accept           = io_in_valid && io_in_ready;
  assign out_fire         = io_out_valid && io_out_ready && !io_flush;
  assign io_out_instValid = io_out_valid ? scan_valid : '0;
  assign io_out_halfTail  = io_out_valid && scan_tail;
  // A packet accepted while the straddling one leaves must see that carry now.
  assign carry_in         = out_fire ? io_out_halfTail : carry;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      carry      <= 1'b0;
      eff_start  <= '0;
      end_offset <= '0;
      io_pd_data <= '0;
      io_out_seq <= '0;
      seq_cnt    <= '0;
    end else if (io_flush) begin
      state <= EMPTY;
      carry <= 1'b0;
    end else begin
      if (out_fire) carry <= io_out_halfTail;
      if (accept) begin
        state      <= FULL;
        io_pd_data <= io_in_data;
        end_offset <= io_in_endOffset;
        eff_start  <= {1'b0, io_in_startOffset} + {4'b0, carry_in};
        io_out_seq <= seq_cnt;
        seq_cnt    <= seq_cnt + 1'b1;
      end else if (out_fire) begin
        state <= EMPTY;
      end
    end
  end

`ifdef PREDECODE_SEQ_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_stallCycles  <= '0;
      io_perf_carryPackets <= '0;
    end else begin
      if (io_out_valid && !io_out_ready && (io_perf_stallCycles != '1))
        io_perf_stallCycles <= io_perf_stallCycles + 1'b1;
      if (accept && carry_in && (io_perf_carryPackets != '1))
        io_perf_carryPackets <= io_perf_carryPackets + 1'b1;
    end
  end
`endif

endmodule
